// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two requesters.
// It accepts one op at a time, drives the ALU from registers, and returns the result on a valid/ready channel.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err
);

  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   cur_id;
  logic   grant0, grant1;

  // V and C only mean something for subtract; illegal ops report no flags at all.
  function automatic logic [2:0] capture_flags(input logic [1:0] op, input logic [2:0] flags);
    logic sub;
    sub = (op == OP_SUB);
    if (op == OP_ILLEGAL) capture_flags = 3'b000;
    else                  capture_flags = {flags[2] & sub, flags[1] & sub, flags[0]};
  endfunction

  always_comb begin
    grant0 = req0_valid & (~req1_valid | FIXED_PRIO | ~ptr);
    grant1 = req1_valid & ~grant0;
  end

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign rsp_valid  = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 | grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cur_id     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 2'b00;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // IDLE -> EXEC: latch the winner's operands into the ALU input registers
        IDLE: begin
          if (grant0 | grant1) begin
            alu_a  <= grant1 ? req1_a  : req0_a;
            alu_b  <= grant1 ? req1_b  : req0_b;
            alu_op <= grant1 ? req1_op : req0_op;
            cur_id <= grant1;
          end
        end
        // EXEC -> RESP: capture the ALU output settled from the registered operands
        EXEC: begin
          rsp_id     <= cur_id;
          rsp_result <= (alu_op == OP_ILLEGAL) ? '0 : alu_result;
          rsp_flags  <= capture_flags(alu_op, alu_flags);
          rsp_err    <= (alu_op == OP_ILLEGAL);
        end
        // RESP -> IDLE: the requester just served drops to lower priority
        RESP: begin
          if (rsp_ready && !FIXED_PRIO) ptr <= ~rsp_id;
        end
        default: ;
      endcase
    end
  end

endmodule
